// File: rtl/sysmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// sysmem_arb_pkg
// Shared types and helpers for the system-memory arbiter slice.
//   arb_state_t  : arbiter FSM states (IDLE, ACK)
//   grant_id_t   : one-bit master identifier (GNT_M0 / GNT_M1)
//   region_t     : address-decode result (RAM, MMIO, UNMAPPED)
//   decode_addr  : classifies a byte address against the RAM window and
//                  the output-byte register address
// ---------------------------------------------------------------------------
package sysmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_t;

    typedef logic grant_id_t;

    localparam grant_id_t GNT_M0 = 1'b0;
    localparam grant_id_t GNT_M1 = 1'b1;

    localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h1000_0000;

    typedef enum logic [1:0] {
        REGION_RAM      = 2'd0,
        REGION_MMIO     = 2'd1,
        REGION_UNMAPPED = 2'd2
    } region_t;

    // The RAM window is bytes 0 .. 4*2^addr_w-1, so an address is inside it
    // exactly when every bit above the byte-in-window field is zero.
    function automatic region_t decode_addr(input logic [31:0] addr,
                                            input int          addr_w,
                                            input logic [31:0] mmio_addr);
        region_t region;
        if ((addr >> (addr_w + 2)) == 32'd0) begin
            region = REGION_RAM;
        end else if (addr == mmio_addr) begin
            region = REGION_MMIO;
        end else begin
            region = REGION_UNMAPPED;
        end
        return region;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Two-requester picker. A lone request always wins; a tie goes to the
// requester that did not win last time (round-robin), or to requester 0
// when SYSMEM_ARB_FIXED_PRIO_EN is defined.
// Optional macro: SYSMEM_ARB_FIXED_PRIO_EN (fixed priority, m0 wins ties).
// Ports:
//   req[1:0]   in   request lines, bit i = master i
//   last_grant in   id of the most recently granted master
//   enable     in   picker may grant this cycle
//   gnt_valid  out  a grant is issued this cycle
//   gnt_id     out  id of the granted master
// ---------------------------------------------------------------------------
module arb_rr2
    import sysmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_id_t  last_grant,
    input  logic       enable,
    output logic       gnt_valid,
    output grant_id_t  gnt_id
);

`ifdef SYSMEM_ARB_FIXED_PRIO_EN
    // History is irrelevant under fixed priority; keep the input visibly sunk.
    grant_id_t unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Purely combinational pick; the caller registers the winner.
    always_comb begin
        gnt_valid = enable && (req != 2'b00);
        gnt_id    = GNT_M0;
        if (req == 2'b10) begin
            gnt_id = GNT_M1;
        end else if (req == 2'b11) begin
`ifdef SYSMEM_ARB_FIXED_PRIO_EN
            gnt_id = GNT_M0;
`else
            gnt_id = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
`endif
        end
    end

endmodule

// File: rtl/sysmem_arbiter.sv
// ---------------------------------------------------------------------------
// sysmem_arbiter
// Shares a single-port byte-writable RAM and the out_byte register between
// two native-interface masters (m0 = CPU, m1 = loader / debug DMA).
// Each access takes two cycles: grant (IDLE, RAM driven from the winning
// request) then ACK (ready pulse, read data returned, MMIO write applied).
// Optional macro: SYSMEM_ARB_FIXED_PRIO_EN (m0 wins every tie).
// Ports:
//   clk, resetn                        clock, async active-low reset
//   m0_/m1_ valid, addr, wdata, wstrb  master requests (wstrb 0 = read)
//   m0_/m1_ ready, rdata               one-cycle completion and read data
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata
//                                      RAM port (read data 1-cycle latency)
//   out_byte, out_byte_en              output byte register and write strobe
// ---------------------------------------------------------------------------
module sysmem_arbiter
    import sysmem_arb_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_ADDR = MMIO_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        out_byte,
    output logic              out_byte_en
);

    arb_state_t  state;
    arb_state_t  next_state;
    grant_id_t   last_grant;
    grant_id_t   gnt_id;
    logic        gnt_valid;

    grant_id_t   lat_id;
    logic [31:0] lat_addr;
    logic [3:0]  lat_wstrb;
    logic [7:0]  lat_wbyte;

    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    region_t     sel_region;
    region_t     lat_region;
    logic [31:0] ack_rdata;
    logic        ack_mmio_wr;

    // Grants are only issued from IDLE, so ACK cycles never see a new winner.
    arb_rr2 u_pick (
        .req        ({m1_valid, m0_valid}),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Route the winning master's request toward the RAM and the latches.
    always_comb begin
        sel_addr   = (gnt_id == GNT_M1) ? m1_addr  : m0_addr;
        sel_wdata  = (gnt_id == GNT_M1) ? m1_wdata : m0_wdata;
        sel_wstrb  = (gnt_id == GNT_M1) ? m1_wstrb : m0_wstrb;
        sel_region = decode_addr(sel_addr, ADDR_W, MMIO_ADDR);
    end

    // The RAM is driven straight from the request in the grant cycle so its
    // registered read data lands exactly in the following ACK cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt_valid && (sel_region == REGION_RAM)) begin
            ram_en    = 1'b1;
            ram_we    = sel_wstrb;
            ram_addr  = sel_addr[ADDR_W+1:2];
            ram_wdata = sel_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ACK always lasts a single cycle, so the arbiter can never hang.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gnt_valid) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction latches and round-robin history. Only the low write byte
    // is kept because RAM data has already been consumed in the grant cycle.
    // last_grant resets to m1 so that m0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= GNT_M1;
            lat_id     <= GNT_M0;
            lat_addr   <= '0;
            lat_wstrb  <= '0;
            lat_wbyte  <= '0;
            out_byte   <= '0;
        end else begin
            if (gnt_valid) begin
                last_grant <= gnt_id;
                lat_id     <= gnt_id;
                lat_addr   <= sel_addr;
                lat_wstrb  <= sel_wstrb;
                lat_wbyte  <= sel_wdata[7:0];
            end
            if (ack_mmio_wr) begin
                out_byte <= lat_wbyte;
            end
        end
    end

    // Completion side: ready, read data and the MMIO write strobe. Any
    // non-zero strobe counts as an MMIO write; unmapped accesses read zero.
    always_comb begin
        lat_region  = decode_addr(lat_addr, ADDR_W, MMIO_ADDR);
        ack_mmio_wr = (state == ACK) && (lat_region == REGION_MMIO) && (lat_wstrb != 4'b0000);
        ack_rdata   = '0;
        if (lat_wstrb == 4'b0000) begin
            case (lat_region)
                REGION_RAM:  ack_rdata = ram_rdata;
                REGION_MMIO: ack_rdata = {24'h000000, out_byte};
                default:     ack_rdata = '0;
            endcase
        end
        m0_ready    = (state == ACK) && (lat_id == GNT_M0);
        m1_ready    = (state == ACK) && (lat_id == GNT_M1);
        m0_rdata    = m0_ready ? ack_rdata : '0;
        m1_rdata    = m1_ready ? ack_rdata : '0;
        out_byte_en = ack_mmio_wr;
    end

endmodule

// File: tb/tb_sysmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sysmem_arbiter
// Self-checking bench for sysmem_arbiter. A byte-writable RAM with one cycle
// of read latency sits on the RAM port; a word-array reference model tracks
// expected memory contents, out_byte and the round-robin history.
// ---------------------------------------------------------------------------
module tb_sysmem_arbiter;

    localparam int          ADDR_W = 10;
    localparam int          WORDS  = 1 << ADDR_W;
    localparam logic [31:0] MMIO   = 32'h1000_0000;
`ifdef SYSMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic              m0_valid, m1_valid;
    logic [31:0]       m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]        m0_wstrb, m1_wstrb;
    logic              m0_ready, m1_ready;
    logic [31:0]       m0_rdata, m1_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [7:0]        out_byte;
    logic              out_byte_en;
    logic              ram_clear;

    int n_compared   = 0;
    int n_mismatched = 0;

    sysmem_arbiter #(.ADDR_W(ADDR_W), .MMIO_ADDR(MMIO)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .out_byte(out_byte), .out_byte_en(out_byte_en)
    );

    always #5 clk = ~clk;

    // Physical RAM attached to the DUT: byte lanes, registered read.
    logic [31:0] ram_mem [0:WORDS-1];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= '0;
            ram_rdata <= '0;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:WORDS-1];
    logic [7:0]  ref_out;
    int          ref_last;

    // Pending requests per master and per-cycle observations.
    logic [31:0] q_addr  [2];
    logic [31:0] q_wdata [2];
    logic [3:0]  q_wstrb [2];
    logic        obs_r0 [16], obs_r1 [16], obs_en [16], obs_obe [16];
    logic [31:0] obs_d0 [16], obs_d1 [16], obs_wd [16];
    logic [3:0]  obs_we [16];
    logic [ADDR_W-1:0] obs_ad [16];

    function automatic int region_of(input logic [31:0] a);
        if (a < 32'(4 * WORDS)) return 0;
        if (a == MMIO) return 1;
        return 2;
    endfunction

    function automatic int pick_tie();
        if (FIXED_PRIO) return 0;
        return (ref_last == 0) ? 1 : 0;
    endfunction

    // Applies one completed access by master id to the model.
    task automatic model_access(input int id, output logic [31:0] rd, output bit obe);
        logic [31:0] word;
        int          r;
        word = q_addr[id] >> 2;
        r    = region_of(q_addr[id]);
        rd   = '0;
        obe  = 1'b0;
        if (q_wstrb[id] == 4'h0) begin
            if (r == 0) rd = ref_mem[word];
            else if (r == 1) rd = {24'h0, ref_out};
        end else if (r == 0) begin
            for (int b = 0; b < 4; b++)
                if (q_wstrb[id][b]) ref_mem[word][8*b +: 8] = q_wdata[id][8*b +: 8];
        end else if (r == 1) begin
            ref_out = q_wdata[id][7:0];
            obe     = 1'b1;
        end
        ref_last = id;
    endtask

    // Drives the queued requests like two well-behaved masters (valid held
    // until ready unless hold keeps them asserted) and records ncyc cycles.
    task automatic applyStimulus(input bit a0, input bit a1, input int ncyc, input bit hold);
        bit act0, act1;
        act0 = a0;
        act1 = a1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            m0_valid = act0; m0_addr = q_addr[0]; m0_wdata = q_wdata[0]; m0_wstrb = q_wstrb[0];
            m1_valid = act1; m1_addr = q_addr[1]; m1_wdata = q_wdata[1]; m1_wstrb = q_wstrb[1];
            @(negedge clk);
            obs_r0[c] = m0_ready;  obs_r1[c] = m1_ready;
            obs_d0[c] = m0_rdata;  obs_d1[c] = m1_rdata;
            obs_en[c] = ram_en;    obs_we[c] = ram_we;
            obs_ad[c] = ram_addr;  obs_wd[c] = ram_wdata;
            obs_obe[c] = out_byte_en;
            if (!hold) begin
                if (m0_ready) act0 = 1'b0;
                if (m1_ready) act1 = 1'b0;
            end
        end
        @(posedge clk); #1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        ram_clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 ram_clear = 1'b0;
        @(negedge clk);
        n_compared++; if (m0_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_m0_ready: got %b want 0", m0_ready); end
        n_compared++; if (m1_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_m1_ready: got %b want 0", m1_ready); end
        n_compared++; if (m0_rdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_m0_rdata: got %h want 0", m0_rdata); end
        n_compared++; if (m1_rdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_m1_rdata: got %h want 0", m1_rdata); end
        n_compared++; if (out_byte !== 8'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_byte: got %h want 0", out_byte); end
        n_compared++; if (out_byte_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_byte_en: got %b want 0", out_byte_en); end
        n_compared++; if (ram_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ram_en: got %b want 0", ram_en); end
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        ref_out  = 8'h0;
        ref_last = 1;
        #2 resetn = 1'b1;
    endtask

    task automatic test_ram_write_read();
        logic [31:0] exp;
        bit          eobe;
        q_addr[0] = 32'h0000_0010; q_wdata[0] = 32'hDEADBEEF; q_wstrb[0] = 4'hF;
        applyStimulus(1'b1, 1'b0, 3, 1'b0);
        model_access(0, exp, eobe);
        n_compared++; if (obs_en[0] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_ram_en: got %b want 1", obs_en[0]); end
        n_compared++; if (obs_we[0] !== 4'hF) begin n_mismatched++; $display("[TB] FAIL wr_ram_we: got %h want f", obs_we[0]); end
        n_compared++; if (obs_ad[0] !== 10'd4) begin n_mismatched++; $display("[TB] FAIL wr_ram_addr: got %0d want 4", obs_ad[0]); end
        n_compared++; if (obs_wd[0] !== q_wdata[0]) begin n_mismatched++; $display("[TB] FAIL wr_ram_wdata: got %h want %h", obs_wd[0], q_wdata[0]); end
        n_compared++; if ({obs_r0[2], obs_r0[1], obs_r0[0]} !== 3'b010) begin n_mismatched++; $display("[TB] FAIL wr_ready_timing: got %b want 010", {obs_r0[2], obs_r0[1], obs_r0[0]}); end
        n_compared++; if (obs_r1[1] !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wr_other_ready: got %b want 0", obs_r1[1]); end
        q_wstrb[0] = 4'h0;
        applyStimulus(1'b1, 1'b0, 3, 1'b0);
        model_access(0, exp, eobe);
        n_compared++; if ({obs_en[0], obs_we[0]} !== 5'b1_0000) begin n_mismatched++; $display("[TB] FAIL rd_ram_ctrl: got en=%b we=%h want en=1 we=0", obs_en[0], obs_we[0]); end
        n_compared++; if (obs_r0[1] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd_ready: got %b want 1", obs_r0[1]); end
        n_compared++; if (obs_d0[1] !== exp) begin n_mismatched++; $display("[TB] FAIL rd_data: got %h want %h", obs_d0[1], exp); end
    endtask

    task automatic test_byte_write();
        logic [31:0] exp;
        bit          eobe;
        q_addr[0] = 32'h0000_0008; q_wdata[0] = 32'h1122_3344; q_wstrb[0] = 4'hF;
        applyStimulus(1'b1, 1'b0, 3, 1'b0);
        model_access(0, exp, eobe);
        q_wdata[0] = 32'h00AB_0000; q_wstrb[0] = 4'b0100;
        applyStimulus(1'b1, 1'b0, 3, 1'b0);
        model_access(0, exp, eobe);
        n_compared++; if (obs_we[0] !== 4'b0100) begin n_mismatched++; $display("[TB] FAIL byte_we: got %b want 0100", obs_we[0]); end
        q_wstrb[0] = 4'h0;
        applyStimulus(1'b1, 1'b0, 3, 1'b0);
        model_access(0, exp, eobe);
        n_compared++; if (obs_d0[1] !== exp) begin n_mismatched++; $display("[TB] FAIL byte_readback: got %h want %h", obs_d0[1], exp); end
    endtask

    task automatic test_mmio();
        logic [31:0] exp;
        bit          eobe;
        q_addr[1] = MMIO; q_wdata[1] = 32'h0000_0041; q_wstrb[1] = 4'h8;
        applyStimulus(1'b0, 1'b1, 3, 1'b0);
        model_access(1, exp, eobe);
        n_compared++; if (obs_en[0] !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mmio_wr_ram_en: got %b want 0", obs_en[0]); end
        n_compared++; if ({obs_obe[2], obs_obe[1], obs_obe[0]} !== {1'b0, eobe, 1'b0}) begin n_mismatched++; $display("[TB] FAIL mmio_strobe: got %b want 0%b0", {obs_obe[2], obs_obe[1], obs_obe[0]}, eobe); end
        n_compared++; if (obs_r1[1] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mmio_wr_ready: got %b want 1", obs_r1[1]); end
        n_compared++; if (out_byte !== ref_out) begin n_mismatched++; $display("[TB] FAIL mmio_out_byte: got %h want %h", out_byte, ref_out); end
        q_addr[0] = MMIO; q_wstrb[0] = 4'h0;
        applyStimulus(1'b1, 1'b0, 3, 1'b0);
        model_access(0, exp, eobe);
        n_compared++; if (obs_en[0] !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mmio_rd_ram_en: got %b want 0", obs_en[0]); end
        n_compared++; if (obs_d0[1] !== exp) begin n_mismatched++; $display("[TB] FAIL mmio_rd_data: got %h want %h", obs_d0[1], exp); end
        n_compared++; if (obs_obe[1] !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mmio_rd_strobe: got %b want 0", obs_obe[1]); end
    endtask

    task automatic test_unmapped();
        logic [31:0] exp;
        bit          eobe;
        logic [31:0] probe [2];
        probe[0] = 32'h2000_0000;
        probe[1] = 32'h0000_1000;
        for (int p = 0; p < 2; p++) begin
            q_addr[0] = probe[p]; q_wdata[0] = 32'hFFFF_FFFF; q_wstrb[0] = 4'h0;
            applyStimulus(1'b1, 1'b0, 3, 1'b0);
            model_access(0, exp, eobe);
            n_compared++; if ({obs_en[1], obs_en[0]} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL unmapped_rd_ram_en: addr %h got %b want 00", probe[p], {obs_en[1], obs_en[0]}); end
            n_compared++; if ({obs_r0[1], obs_r0[0]} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL unmapped_rd_ready: addr %h got %b want 10", probe[p], {obs_r0[1], obs_r0[0]}); end
            n_compared++; if (obs_d0[1] !== exp) begin n_mismatched++; $display("[TB] FAIL unmapped_rd_data: addr %h got %h want %h", probe[p], obs_d0[1], exp); end
            q_wstrb[0] = 4'hF;
            applyStimulus(1'b1, 1'b0, 3, 1'b0);
            model_access(0, exp, eobe);
            n_compared++; if ({obs_en[0], obs_obe[1], obs_r0[1]} !== 3'b001) begin n_mismatched++; $display("[TB] FAIL unmapped_wr: addr %h got en/strobe/ready %b want 001", probe[p], {obs_en[0], obs_obe[1], obs_r0[1]}); end
            n_compared++; if (out_byte !== ref_out) begin n_mismatched++; $display("[TB] FAIL unmapped_wr_out_byte: got %h want %h", out_byte, ref_out); end
        end
    endtask

    task automatic test_alternation();
        logic [31:0] exp;
        bit          eobe;
        int          g;
        q_addr[0] = 32'h0000_0010; q_wstrb[0] = 4'h0;
        q_addr[1] = 32'h0000_0008; q_wstrb[1] = 4'h0;
        applyStimulus(1'b1, 1'b1, 8, 1'b1);
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) begin
                n_compared++; if ({obs_r1[c], obs_r0[c]} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL alt_idle_ready: cycle %0d got %b want 00", c, {obs_r1[c], obs_r0[c]}); end
            end else begin
                g = pick_tie();
                model_access(g, exp, eobe);
                n_compared++; if ({obs_r1[c], obs_r0[c]} !== ((g == 1) ? 2'b10 : 2'b01)) begin n_mismatched++; $display("[TB] FAIL alt_grant: cycle %0d got {m1,m0}=%b want m%0d", c, {obs_r1[c], obs_r0[c]}, g); end
                n_compared++; if (((g == 1) ? obs_d1[c] : obs_d0[c]) !== exp) begin n_mismatched++; $display("[TB] FAIL alt_rdata: cycle %0d got %h want %h", c, (g == 1) ? obs_d1[c] : obs_d0[c], exp); end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] exp0, exp1;
        bit          eobe;
        int          g;
        q_addr[1] = MMIO; q_wdata[1] = 32'h0000_0055; q_wstrb[1] = 4'h1;
        @(posedge clk); #1;
        m1_valid = 1'b1; m1_addr = q_addr[1]; m1_wdata = q_wdata[1]; m1_wstrb = q_wstrb[1];
        @(negedge clk);
        @(posedge clk); #2;
        resetn   = 1'b0;
        m1_valid = 1'b0;
        #1;
        n_compared++; if ({m1_ready, out_byte_en} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL abort_ready: got ready=%b strobe=%b want 0 0", m1_ready, out_byte_en); end
        n_compared++; if (out_byte !== 8'h00) begin n_mismatched++; $display("[TB] FAIL abort_out_byte: got %h want 00", out_byte); end
        @(negedge clk);
        n_compared++; if (m1_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_late_ready: got %b want 0", m1_ready); end
        @(posedge clk); #2;
        resetn   = 1'b1;
        ref_out  = 8'h00;
        ref_last = 1;
        q_addr[0] = 32'h0000_0010; q_wstrb[0] = 4'h0;
        q_addr[1] = 32'h0000_0008; q_wstrb[1] = 4'h0;
        applyStimulus(1'b1, 1'b1, 5, 1'b0);
        g = pick_tie();
        model_access(g, exp0, eobe);
        model_access(1 - g, exp1, eobe);
        n_compared++; if ({obs_r1[1], obs_r0[1]} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL abort_first_tie: got {m1,m0}=%b want 01", {obs_r1[1], obs_r0[1]}); end
        n_compared++; if ({obs_r1[3], obs_r0[3]} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL abort_second: got {m1,m0}=%b want 10", {obs_r1[3], obs_r0[3]}); end
        n_compared++; if (obs_d0[1] !== exp0 || obs_d1[3] !== exp1) begin n_mismatched++; $display("[TB] FAIL abort_rdata: got %h/%h want %h/%h", obs_d0[1], obs_d1[3], exp0, exp1); end
        n_compared++; if (out_byte !== ref_out) begin n_mismatched++; $display("[TB] FAIL abort_no_commit: got %h want %h", out_byte, ref_out); end
    endtask

    task automatic gen_req(input int id);
        int cls;
        cls = $urandom_range(0, 9);
        if (cls < 6)       q_addr[id] = 32'($urandom_range(0, 15)) << 2;
        else if (cls == 6) q_addr[id] = 32'($urandom_range(WORDS - 4, WORDS - 1)) << 2;
        else if (cls == 7) q_addr[id] = MMIO;
        else if (cls == 8) q_addr[id] = 32'(4 * WORDS) + (32'($urandom_range(0, 7)) << 2);
        else               q_addr[id] = $urandom | 32'h8000_0000;
        q_wdata[id] = $urandom;
        q_wstrb[id] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
    endtask

    task automatic test_random();
        int          ord [2];
        int          n, id, gc, ac;
        bit          pair;
        logic [31:0] exp, a, d;
        bit          eobe;
        for (int it = 0; it < 40; it++) begin
            gen_req(0);
            gen_req(1);
            pair = ($urandom_range(0, 3) == 0);
            if (pair) begin
                ord[0] = pick_tie(); ord[1] = 1 - ord[0]; n = 2;
                applyStimulus(1'b1, 1'b1, 5, 1'b0);
            end else begin
                ord[0] = $urandom_range(0, 1); ord[1] = 0; n = 1;
                applyStimulus(ord[0] == 0, ord[0] == 1, 3, 1'b0);
            end
            for (int k = 0; k < n; k++) begin
                id = ord[k];
                gc = 2 * k;
                ac = gc + 1;
                a  = q_addr[id];
                model_access(id, exp, eobe);
                n_compared++; if ({obs_r1[gc], obs_r0[gc]} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rnd_grant_ready: it %0d got %b want 00", it, {obs_r1[gc], obs_r0[gc]}); end
                n_compared++; if (obs_en[gc] !== (region_of(a) == 0)) begin n_mismatched++; $display("[TB] FAIL rnd_ram_en: it %0d addr %h got %b", it, a, obs_en[gc]); end
                if (region_of(a) == 0) begin
                    n_compared++; if ({obs_we[gc], obs_ad[gc]} !== {q_wstrb[id], a[ADDR_W+1:2]}) begin n_mismatched++; $display("[TB] FAIL rnd_ram_ctrl: it %0d got we=%h addr=%0d want we=%h addr=%0d", it, obs_we[gc], obs_ad[gc], q_wstrb[id], a[ADDR_W+1:2]); end
                    if (q_wstrb[id] != 4'h0) begin
                        n_compared++; if (obs_wd[gc] !== q_wdata[id]) begin n_mismatched++; $display("[TB] FAIL rnd_ram_wdata: it %0d got %h want %h", it, obs_wd[gc], q_wdata[id]); end
                    end
                end
                n_compared++; if ({obs_r1[ac], obs_r0[ac]} !== ((id == 1) ? 2'b10 : 2'b01)) begin n_mismatched++; $display("[TB] FAIL rnd_ready: it %0d got {m1,m0}=%b want m%0d", it, {obs_r1[ac], obs_r0[ac]}, id); end
                if (q_wstrb[id] == 4'h0) begin
                    d = (id == 1) ? obs_d1[ac] : obs_d0[ac];
                    n_compared++; if (d !== exp) begin n_mismatched++; $display("[TB] FAIL rnd_rdata: it %0d addr %h got %h want %h", it, a, d, exp); end
                end
                n_compared++; if (obs_obe[ac] !== eobe) begin n_mismatched++; $display("[TB] FAIL rnd_strobe: it %0d got %b want %b", it, obs_obe[ac], eobe); end
            end
            n_compared++; if (out_byte !== ref_out) begin n_mismatched++; $display("[TB] FAIL rnd_out_byte: it %0d got %h want %h", it, out_byte, ref_out); end
        end
    endtask

    initial begin
        resetn    = 1'b0;
        ram_clear = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        for (int i = 0; i < 2; i++) begin
            q_addr[i] = '0; q_wdata[i] = '0; q_wstrb[i] = '0;
        end
        test_reset();
        test_ram_write_read();
        test_byte_write();
        test_mmio();
        test_unmapped();
        test_alternation();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
